sync_arith_result_buffer: RTL and testbench
===========================================

Name: sync_arith_result_buffer

Overview:
Downstream stage of the synchronous arithmetic unit. Captures each {result, status, opcode} triple the unit produces into a DEPTH-entry FIFO and presents it to a consumer over a valid/ready handshake. Maintains a sticky OR of all captured status bits and a saturating count of results dropped because the FIFO was full. The arithmetic unit cannot be stalled, so `o_full` and `o_almost_full` are advisory to the issuing logic.

Parameters:
- M, 32, result data width; matches the arithmetic unit's M.
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  arithmetic unit result valid this cycle
- i_result  in  M  arithmetic unit o_result
- i_status  in  4  arithmetic unit o_status
- i_op  in  4  opcode that produced the result (tag)
- o_full  out  1  count == DEPTH
- o_almost_full  out  1  count >= DEPTH-1
- o_valid  out  1  head entry available
- i_ready  in  1  consumer accepts head entry
- o_data  out  M  head result
- o_data_status  out  4  head status
- o_data_op  out  4  head opcode tag
- o_count  out  AW+1  entries stored, 0..DEPTH
- i_clear_sticky  in  1  clears sticky status and drop counter
- o_sticky_status  out  4  OR of the status of every accepted entry since the last clear or reset
- o_drop_cnt  out  8  dropped-result count, saturates at 255

Behaviour:
- Reset (async assert, all outputs):
  - wr_ptr, rd_ptr and count = 0.
  - o_valid = 0, o_full = 0, o_almost_full = 0.
  - o_sticky_status = 0, o_drop_cnt = 0.
  - o_data, o_data_status and o_data_op = 0.
  - Storage array is not reset.
- Reset mid-operation: all stored entries are discarded immediately; nothing is presented after release.
- Pop: o_valid && i_ready.
- Push: i_valid && (!o_full || pop).
  - At full, a simultaneous pop frees the slot, so the push is accepted.
- Drop: i_valid && o_full && !pop.
  - The entry is discarded.
  - o_drop_cnt increments, saturating at 255.
- Count update:
  - count += push − pop.
  - push && pop leaves count unchanged; both pointers advance.
- Pointers:
  - AW bits each, wrap from DEPTH−1 to 0.
  - Full and empty are resolved by count, not by pointer comparison.
- Output style: first-word-fall-through.
  - o_valid = (count != 0).
  - o_data, o_data_status and o_data_op reflect mem[rd_ptr] while o_valid = 1; they are forced to 0 while o_valid = 0.
- Latency:
  - An entry pushed in cycle N is visible at the head in cycle N+1 if the FIFO was empty.
  - There is no same-cycle bypass.
- Empty: i_ready while o_valid = 0 has no effect; count never underflows.
- Ordering: strict FIFO; the op tag stays paired with its result and status.
- Sticky status:
  - Updated each clock as sticky_next = (i_clear_sticky ? 0 : sticky) | (push ? i_status : 0).
  - Clear together with a push: only the new status remains.
  - Dropped entries do not contribute.
- Drop counter on i_clear_sticky:
  - Reset to 0.
  - If a drop occurs in the same cycle, the counter becomes 1.
- All outputs are registered except:
  - o_data, o_data_status and o_data_op (array read at rd_ptr);
  - o_valid, o_full and o_almost_full (decoded from the registered count).

Test Plan:
1. Reset → empty stream:
   - Stimulus: assert i_reset, release, then idle for 3 cycles.
   - Required: o_valid = 0, o_count = 0, o_data = 0, o_sticky_status = 0, o_drop_cnt = 0.
2. Single push, then pop:
   - Stimulus: push result 1, status 4'b0001, op 4'b0000, with i_ready = 0.
   - Required: next cycle o_valid = 1, o_data = 1, o_data_op = 0, o_count = 1.
   - Then assert i_ready for 1 cycle → o_valid = 0, o_count = 0.
3. Fill to DEPTH and overflow:
   - Stimulus: push values 10..17 with i_ready = 0.
   - Required: o_almost_full rises after the 7th push; o_full = 1 with o_count = 8 after the 8th.
   - Then push 99 and 100 → o_drop_cnt = 2, o_count stays 8.
   - Then drain → sequence 10..17 in order; 99 is never seen.
4. Simultaneous push and pop at full:
   - Stimulus: FIFO full (values 10..17); i_valid with value 50 and i_ready together.
   - Required: pops 10, o_count stays 8, o_drop_cnt unchanged; 50 emerges after 17.
5. Sticky status and clear:
   - Stimulus: push statuses 4'b0010 and 4'b1000 → o_sticky_status = 4'b1010.
   - Then i_clear_sticky together with a push of status 4'b0100 → o_sticky_status = 4'b0100, o_drop_cnt = 0.
6. Async reset mid-stream:
   - Stimulus: 3 entries stored; assert i_reset between clock edges.
   - Required: o_valid and o_count go to 0 before the next edge; after release, a push of 7 yields o_data = 7 as the only entry.

Source files
------------

// File: rtl/sync_arith_result_buffer.sv
// rtl/sync_arith_result_buffer.sv - FIFO for arithmetic results with sticky status and drop counter
// Entries are {op, status, result}; full/empty come from the count, never from pointer comparison.
module sync_arith_result_buffer #(
  parameter int M     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           i_reset,
  input  logic           i_valid,
  input  logic [M-1:0]   i_result,
  input  logic [3:0]     i_status,
  input  logic [3:0]     i_op,
  output logic           o_full,
  output logic           o_almost_full,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [M-1:0]   o_data,
  output logic [3:0]     o_data_status,
  output logic [3:0]     o_data_op,
  output logic [AW:0]    o_count,
  input  logic           i_clear_sticky,
  output logic [3:0]     o_sticky_status,
  output logic [7:0]     o_drop_cnt
);

  localparam int            EW        = M + 8;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [3:0]    sticky;
  logic [3:0]    sticky_next;
  logic [7:0]    drop_cnt;
  logic [7:0]    drop_next;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          drop;

  assign o_valid       = (count != '0);
  assign o_full        = (count == FULL_CNT);
  assign o_almost_full = (count >= AFULL_CNT);

  // The producer cannot stall, so a pop in the same cycle is what makes room at full.
  assign pop  = o_valid && i_ready;
  assign push = i_valid && (!o_full || pop);
  assign drop = i_valid && o_full && !pop;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  always_comb begin
    sticky_next = i_clear_sticky ? 4'b0000 : sticky;
    if (push) begin
      sticky_next = sticky_next | i_status;
    end
  end

  always_comb begin
    drop_next = i_clear_sticky ? 8'd0 : drop_cnt;
    if (drop && (drop_next != 8'hff)) begin
      drop_next = drop_next + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sticky   <= 4'b0000;
      drop_cnt <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count    <= count_next;
      sticky   <= sticky_next;
      drop_cnt <= drop_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_op, i_status, i_result};
    end
  end

  // Head is read straight from the array; zeroed while empty so stale entries never leak out.
  assign head          = mem[rd_ptr];
  assign o_data        = o_valid ? head[M-1:0]   : '0;
  assign o_data_status = o_valid ? head[M+3:M]   : 4'b0000;
  assign o_data_op     = o_valid ? head[M+7:M+4] : 4'b0000;

  assign o_count         = count;
  assign o_sticky_status = sticky;
  assign o_drop_cnt      = drop_cnt;

endmodule

// File: tb/tb_sync_arith_result_buffer.sv
// tb/tb_sync_arith_result_buffer.sv - scoreboard bench for sync_arith_result_buffer
module tb_sync_arith_result_buffer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_result = '0;
  logic [3:0]  i_status = '0;
  logic [3:0]  i_op = '0;
  logic        o_full;
  logic        o_almost_full;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic [3:0]  o_data_status;
  logic [3:0]  o_data_op;
  logic [3:0]  o_count;
  logic        i_clear_sticky = 1'b0;
  logic [3:0]  o_sticky_status;
  logic [7:0]  o_drop_cnt;

  int total = 0;
  int bad = 0;
  logic [39:0] exp_q[$];

  sync_arith_result_buffer #(.M(32), .DEPTH(8)) dut (
    .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_result(i_result),
    .i_status(i_status), .i_op(i_op), .o_full(o_full), .o_almost_full(o_almost_full),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_data_status(o_data_status),
    .o_data_op(o_data_op), .o_count(o_count), .i_clear_sticky(i_clear_sticky),
    .o_sticky_status(o_sticky_status), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [31:0] r, input logic [3:0] s, input logic [3:0] op,
                            input bit accepted);
    i_valid = 1'b1; i_result = r; i_status = s; i_op = op;
    if (accepted) exp_q.push_back({op, s, r});
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    i_ready = 1'b1;
    repeat (n) tick();
    i_ready = 1'b0;
  endtask

  // Monitor: every handshake pops the scoreboard and compares the whole head entry.
  always @(negedge clk) begin
    if (!i_reset && o_valid && i_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got=%0h want=none", {o_data_op, o_data_status, o_data});
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({o_data_op, o_data_status, o_data} !== e) begin
          bad++;
          $display("FAIL pop_data got=%0h want=%0h", {o_data_op, o_data_status, o_data}, e);
        end
      end
    end
  end

  initial begin
    // 1: reset, idle
    repeat (2) tick();
    i_reset = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_data", o_data, 0);
    chk("rst_sticky", 32'(o_sticky_status), 0);
    chk("rst_drop", 32'(o_drop_cnt), 0);
    chk("rst_full", 32'({o_full, o_almost_full}), 0);

    // 2: single push then pop
    push_entry(32'd1, 4'b0001, 4'b0000, 1'b1);
    chk("one_valid", 32'(o_valid), 1);
    chk("one_data", o_data, 1);
    chk("one_op", 32'(o_data_op), 0);
    chk("one_count", 32'(o_count), 1);
    drain(1);
    chk("one_valid_after", 32'(o_valid), 0);
    chk("one_count_after", 32'(o_count), 0);
    chk("one_data_zero", o_data, 0);

    // 3: fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      push_entry(32'(10 + i), 4'b0000, 4'(i), 1'b1);
      if (i == 5) chk("afull_at6", 32'(o_almost_full), 0);
      if (i == 6) begin
        chk("afull_at7", 32'(o_almost_full), 1);
        chk("full_at7", 32'(o_full), 0);
      end
    end
    chk("full_at8", 32'(o_full), 1);
    chk("count_at8", 32'(o_count), 8);
    push_entry(32'd99, 4'b0000, 4'd9, 1'b0);
    push_entry(32'd100, 4'b0000, 4'd9, 1'b0);
    chk("drop_two", 32'(o_drop_cnt), 2);
    chk("count_held", 32'(o_count), 8);
    drain(8);
    chk("drained_count", 32'(o_count), 0);

    // 4: push and pop together at full
    for (int i = 0; i < 8; i++) push_entry(32'(10 + i), 4'b0000, 4'(i), 1'b1);
    i_ready = 1'b1;
    push_entry(32'd50, 4'b0000, 4'hc, 1'b1);
    i_ready = 1'b0;
    chk("pp_count", 32'(o_count), 8);
    chk("pp_drop", 32'(o_drop_cnt), 2);
    chk("pp_head", o_data, 11);
    drain(8);
    chk("pp_empty", 32'(o_count), 0);

    // 5: sticky status and clear
    i_clear_sticky = 1'b1;
    tick();
    i_clear_sticky = 1'b0;
    chk("clr_sticky", 32'(o_sticky_status), 0);
    chk("clr_drop", 32'(o_drop_cnt), 0);
    push_entry(32'd2, 4'b0010, 4'd1, 1'b1);
    push_entry(32'd3, 4'b1000, 4'd2, 1'b1);
    chk("sticky_or", 32'(o_sticky_status), 32'b1010);
    i_clear_sticky = 1'b1;
    push_entry(32'd4, 4'b0100, 4'd3, 1'b1);
    i_clear_sticky = 1'b0;
    chk("sticky_clr_push", 32'(o_sticky_status), 32'b0100);
    chk("drop_clr_push", 32'(o_drop_cnt), 0);

    // 6: async reset between edges with 3 entries stored
    chk("pre_rst_count", 32'(o_count), 3);
    @(posedge clk);
    #3;
    i_reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_valid", 32'(o_valid), 0);
    chk("async_count", 32'(o_count), 0);
    chk("async_sticky", 32'(o_sticky_status), 0);
    tick();
    i_reset = 1'b0;
    tick();
    chk("post_rst_valid", 32'(o_valid), 0);
    push_entry(32'd7, 4'b0000, 4'd5, 1'b1);
    chk("post_rst_data", o_data, 7);
    chk("post_rst_count", 32'(o_count), 1);
    drain(1);
    chk("post_rst_empty", 32'(o_count), 0);

    // Drop saturation, dropped status ignored, clear with simultaneous drop
    for (int i = 0; i < 8; i++) push_entry(32'(20 + i), 4'b0000, 4'(i), 1'b1);
    i_valid = 1'b1; i_result = 32'hdead; i_status = 4'b1111;
    repeat (260) tick();
    chk("drop_sat", 32'(o_drop_cnt), 255);
    chk("drop_no_sticky", 32'(o_sticky_status), 0);
    i_clear_sticky = 1'b1;
    tick();
    i_clear_sticky = 1'b0;
    i_valid = 1'b0;
    chk("drop_clr_one", 32'(o_drop_cnt), 1);
    drain(8);
    chk("final_count", 32'(o_count), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
